param_fifo: RTL and testbench

PARAM_FIFO -- requirements
Module: param_fifo

---
 rtl/fifo_pkg.sv | 12 +
 rtl/fifo_mem.sv | 24 ++
 rtl/param_fifo.sv | 84 ++++++++
 tb/tb_param_fifo.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared defaults and pointer sizing for the parameterised FIFO.
package fifo_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH  = 8;

  // Address bits needed to index a power-of-two number of entries.
  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// FIFO storage: register array, one synchronous write port, one asynchronous read port.
module fifo_mem #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int AW     = 3
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Contents are data only and are never reset; pointers define validity.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/param_fifo.sv
// Synchronous first-word fall-through FIFO with sticky overflow/underflow flags.
// Define FIFO_OVERWRITE_EN to make a push while full replace the oldest entry.
module param_fifo
  import fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int AF_LVL = DEPTH - 1,
  parameter int AE_LVL = 1
) (
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic                   wEnable,
  input  logic [DATA_W-1:0]      wData,
  input  logic                   rEnable,
  input  logic                   clrErr,
  output logic [DATA_W-1:0]      rData,
  output logic                   fifoEmpty,
  output logic                   fifoFull,
  output logic                   almostEmpty,
  output logic                   almostFull,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int AW = ptr_w(DEPTH);
  localparam int CW = AW + 1;

`ifdef FIFO_OVERWRITE_EN
  localparam bit OVERWRITE = 1'b1;
`else
  localparam bit OVERWRITE = 1'b0;
`endif

  logic [CW-1:0]     wr_ptr, rd_ptr;
  logic [DATA_W-1:0] head;
  logic              do_pop, do_push, adv_rd;
  logic              ovf_set, unf_set;

  // Extra pointer MSB makes the difference span 0..DEPTH, separating full from empty.
  assign count       = wr_ptr - rd_ptr;
  assign fifoEmpty   = (count == '0);
  assign fifoFull    = (count == CW'(DEPTH));
  assign almostEmpty = (count <= CW'(AE_LVL));
  assign almostFull  = (count >= CW'(AF_LVL));
  assign rData       = fifoEmpty ? '0 : head;

  assign do_pop  = rEnable && !fifoEmpty;
  assign do_push = wEnable && (!fifoFull || do_pop || OVERWRITE);
  // When overwriting, the oldest slot is the write slot, so the read side steps past it.
  assign adv_rd  = do_pop || (OVERWRITE && wEnable && fifoFull && !rEnable);
  assign ovf_set = wEnable && fifoFull && !rEnable;
  assign unf_set = rEnable && fifoEmpty;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (adv_rd)  rd_ptr <= rd_ptr + 1'b1;
      // A fresh error in the clearing cycle wins over the clear.
      overflow  <= (overflow  && !clrErr) || ovf_set;
      underflow <= (underflow && !clrErr) || unf_set;
    end
  end

  fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_mem (
    .clk   (clk),
    .we    (do_push),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (wData),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (head)
  );

endmodule

// File: tb/tb_param_fifo.sv
// Directed bench for param_fifo (DEPTH=4) with a queue scoreboard; honours FIFO_OVERWRITE_EN.
module tb_param_fifo;

`ifdef FIFO_OVERWRITE_EN
  localparam bit OVR = 1'b1;
`else
  localparam bit OVR = 1'b0;
`endif

  logic       tb_clk = 1'b0;
  logic       n_rst;
  logic       wEnable, rEnable, clrErr;
  logic [7:0] wData;
  logic [7:0] rData;
  logic       fifoEmpty, fifoFull, almostEmpty, almostFull;
  logic [2:0] count;
  logic       overflow, underflow;

  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] q[$];
  bit         m_ovf, m_unf;

  always #5 tb_clk = ~tb_clk;

  param_fifo #(.DATA_W(8), .DEPTH(4)) dut (
    .clk         (tb_clk),
    .n_rst       (n_rst),
    .wEnable     (wEnable),
    .wData       (wData),
    .rEnable     (rEnable),
    .clrErr      (clrErr),
    .rData       (rData),
    .fifoEmpty   (fifoEmpty),
    .fifoFull    (fifoFull),
    .almostEmpty (almostEmpty),
    .almostFull  (almostFull),
    .count       (count),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [7:0] exp_d;
    int         sz;
    sz    = q.size();
    exp_d = (sz > 0) ? q[0] : 8'h00;
    chk({tag, ".rData"},       32'(rData),       32'(exp_d));
    chk({tag, ".count"},       32'(count),       32'(sz));
    chk({tag, ".fifoEmpty"},   32'(fifoEmpty),   32'(sz == 0));
    chk({tag, ".fifoFull"},    32'(fifoFull),    32'(sz == 4));
    chk({tag, ".almostEmpty"}, 32'(almostEmpty), 32'(sz <= 1));
    chk({tag, ".almostFull"},  32'(almostFull),  32'(sz >= 3));
    chk({tag, ".overflow"},    32'(overflow),    32'(m_ovf));
    chk({tag, ".underflow"},   32'(underflow),   32'(m_unf));
  endtask

  // Update the scoreboard for one clocked transaction, then apply it to the DUT.
  task automatic step(input logic we, input logic [7:0] wd, input logic re, input logic clr);
    bit full, empty, pop_ok;
    full   = (q.size() == 4);
    empty  = (q.size() == 0);
    pop_ok = re && !empty;
    if (clr) begin m_ovf = 1'b0; m_unf = 1'b0; end
    if (re && empty)        m_unf = 1'b1;
    if (we && full && !re)  m_ovf = 1'b1;
    if (pop_ok) void'(q.pop_front());
    if (we) begin
      if (!full || pop_ok) q.push_back(wd);
      else if (OVR) begin void'(q.pop_front()); q.push_back(wd); end
    end
    wEnable = we; wData = wd; rEnable = re; clrErr = clr;
    @(posedge tb_clk); #1;
    wEnable = 1'b0; rEnable = 1'b0; clrErr = 1'b0; wData = 8'h00;
  endtask

  initial begin
    n_rst = 1'b0; wEnable = 1'b0; rEnable = 1'b0; clrErr = 1'b0; wData = 8'h00;
    m_ovf = 1'b0; m_unf = 1'b0;

    // Reset
    repeat (2) @(posedge tb_clk);
    #1;
    check_all("in_reset");
    n_rst = 1'b1;
    @(posedge tb_clk); #1;
    check_all("post_reset");
    chk("rst.empty", 32'(fifoEmpty), 32'd1);
    chk("rst.count", 32'(count), 32'd0);
    chk("rst.rdata", 32'(rData), 32'd0);

    // Fall-through and ordering
    step(1, 8'hF0, 0, 0); check_all("push_f0");
    chk("ft.first", 32'(rData), 32'hF0);
    step(1, 8'h0F, 0, 0); check_all("push_0f");
    chk("ft.head", 32'(rData), 32'hF0);
    step(0, 8'h00, 1, 0); check_all("pop1");
    chk("ft.second", 32'(rData), 32'h0F);
    chk("ft.count", 32'(count), 32'd1);
    step(0, 8'h00, 1, 0); check_all("pop2");

    // Fill and wrap
    step(1, 8'h11, 0, 0); step(1, 8'h22, 0, 0);
    step(1, 8'h33, 0, 0); step(1, 8'h44, 0, 0);
    check_all("fill");
    chk("fill.full", 32'(fifoFull), 32'd1);
    chk("fill.af", 32'(almostFull), 32'd1);
    chk("fill.count", 32'(count), 32'd4);
    step(0, 8'h00, 1, 0); step(0, 8'h00, 1, 0); check_all("pop2_of_4");
    step(1, 8'h55, 0, 0); step(1, 8'h66, 0, 0); check_all("wrap_push");
    chk("wrap.h0", 32'(rData), 32'h33);
    step(0, 8'h00, 1, 0); chk("wrap.h1", 32'(rData), 32'h44);
    step(0, 8'h00, 1, 0); chk("wrap.h2", 32'(rData), 32'h55);
    step(0, 8'h00, 1, 0); chk("wrap.h3", 32'(rData), 32'h66);
    step(0, 8'h00, 1, 0); check_all("wrap_drained");

    // Push while full
    step(1, 8'hA1, 0, 0); step(1, 8'hB2, 0, 0);
    step(1, 8'hC3, 0, 0); step(1, 8'hD4, 0, 0);
    step(1, 8'hE5, 0, 0); check_all("full_push");
    chk("fullpush.rdata", 32'(rData), OVR ? 32'hB2 : 32'hA1);
    chk("fullpush.count", 32'(count), 32'd4);
    chk("fullpush.ovf", 32'(overflow), 32'd1);
    step(0, 8'h00, 0, 1); check_all("clr_ovf");
    step(1, 8'hF6, 1, 0); check_all("full_push_pop");
    chk("fullpp.ovf", 32'(overflow), 32'd0);
    chk("fullpp.count", 32'(count), 32'd4);
    repeat (4) step(0, 8'h00, 1, 0);
    check_all("full_drained");

    // Pop while empty, then clear
    step(0, 8'h00, 1, 0); check_all("pop_empty");
    chk("unf.set", 32'(underflow), 32'd1);
    chk("unf.count", 32'(count), 32'd0);
    step(0, 8'h00, 0, 1); check_all("unf_clr");
    chk("unf.clr", 32'(underflow), 32'd0);

    // Simultaneous push and pop
    step(1, 8'h01, 0, 0); step(1, 8'h02, 0, 0);
    step(1, 8'h03, 1, 0); check_all("pp_mid");
    chk("pp.count", 32'(count), 32'd2);
    chk("pp.rdata", 32'(rData), 32'h02);
    step(0, 8'h00, 1, 0); step(0, 8'h00, 1, 0); check_all("pp_drain");
    step(1, 8'h77, 1, 0); check_all("pp_empty");
    chk("ppe.count", 32'(count), 32'd1);
    chk("ppe.unf", 32'(underflow), 32'd1);
    chk("ppe.rdata", 32'(rData), 32'h77);
    step(0, 8'h00, 1, 0); check_all("ppe_pop");
    // Error in the same cycle as clear keeps the flag
    step(0, 8'h00, 1, 1); check_all("clr_vs_err");
    chk("clrerr.unf", 32'(underflow), 32'd1);
    step(0, 8'h00, 0, 1); check_all("clr_final");

    // Mid-operation asynchronous reset
    step(0, 8'h00, 1, 0);
    step(1, 8'h9A, 0, 0); step(1, 8'hBC, 0, 0); check_all("pre_midreset");
    #2 n_rst = 1'b0;
    #1;
    q.delete(); m_ovf = 1'b0; m_unf = 1'b0;
    check_all("midreset_async");
    @(posedge tb_clk); #1;
    n_rst = 1'b1;
    @(posedge tb_clk); #1;
    check_all("midreset_release");
    step(1, 8'h5A, 0, 0); check_all("after_midreset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
